// File: rtl/reg_commit_scheduler_pkg.sv
// Shared types for the register-file commit scheduler.
// Macros: ROB_WIDTH_BIT (tag width), COMMIT_BUF_DEPTH_BIT (default buffer depth log2).
package reg_commit_scheduler_pkg;

`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

`ifndef COMMIT_BUF_DEPTH_BIT
`define COMMIT_BUF_DEPTH_BIT 2
`endif

    localparam int RW = `ROB_WIDTH_BIT;
    localparam int DEPTH_BIT_DEF = `COMMIT_BUF_DEPTH_BIT;

    typedef logic [RW-1:0] rob_id_t;

    typedef struct packed {
        logic [4:0]  reg_id;
        logic [31:0] val;
        rob_id_t     rob_id;
    } commit_ent_t;

endpackage

// File: rtl/reg_commit_scheduler_if.sv
// Commit, write-port and lookup bundle of the commit scheduler.
// master = ROB/dispatch side, slave = scheduler side.
interface reg_commit_scheduler_if;
    import reg_commit_scheduler_pkg::*;

    logic        rdy_in;
    logic        rob_clear;
    logic        commit_valid;
    logic        commit_ready;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_val;
    rob_id_t     commit_rob_id;
    logic [4:0]  set_reg_id;
    logic [31:0] set_val;
    rob_id_t     set_reg_on_rob_id;
    logic [4:0]  q_id1;
    logic [4:0]  q_id2;
    logic        q_hit1;
    logic        q_hit2;
    logic [31:0] q_val1;
    logic [31:0] q_val2;
    logic        empty;

    modport master (
        output rdy_in, rob_clear, commit_valid, commit_reg_id,
        output commit_val, commit_rob_id, q_id1, q_id2,
        input  commit_ready, set_reg_id, set_val, set_reg_on_rob_id,
        input  q_hit1, q_hit2, q_val1, q_val2, empty
    );

    modport slave (
        input  rdy_in, rob_clear, commit_valid, commit_reg_id,
        input  commit_val, commit_rob_id, q_id1, q_id2,
        output commit_ready, set_reg_id, set_val, set_reg_on_rob_id,
        output q_hit1, q_hit2, q_val1, q_val2, empty
    );

endinterface

// File: rtl/reg_commit_scheduler_commit_buffer.sv
// Circular FIFO of retired writes; entries exposed for the bypass scan.
module reg_commit_scheduler_commit_buffer
    import reg_commit_scheduler_pkg::*;
#(
    parameter  int DEPTH_BIT = DEPTH_BIT_DEF,
    localparam int DEPTH     = 1 << DEPTH_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enq_i,
    input  logic                 deq_i,
    input  commit_ent_t          wdata_i,
    output commit_ent_t          head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output commit_ent_t          ents_o [DEPTH],
    output logic [DEPTH_BIT-1:0] head_ptr_o,
    output logic [DEPTH_BIT:0]   count_o
);

    localparam int                 CW       = DEPTH_BIT + 1;
    localparam logic [DEPTH_BIT:0] FULL_CNT = CW'(DEPTH);

    commit_ent_t          ents_q [DEPTH];
    logic [DEPTH_BIT-1:0] head_q, tail_q;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 enq, deq;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign enq        = enq_i && !full_o;
    assign deq        = deq_i && !empty_o;
    assign head_o     = ents_q[head_q];
    assign ents_o     = ents_q;
    assign head_ptr_o = head_q;
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + DEPTH_BIT'(1);
            if (deq) head_q <= head_q + DEPTH_BIT'(1);
            count_q <= count_d;
        end
    end

    // Payload needs no reset: only slots below count are ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) ents_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/reg_commit_scheduler.sv
// Drains ROB retirements into the single RF write port, with dispatch bypass lookup.
// Macro COMMIT_BYPASS_EN: an empty buffer lets a commit write the RF in the same cycle.
module reg_commit_scheduler
    import reg_commit_scheduler_pkg::*;
#(
    parameter int DEPTH_BIT = DEPTH_BIT_DEF
) (
    input logic                   clk_in,
    input logic                   rst_in,
    reg_commit_scheduler_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam int CW    = DEPTH_BIT + 1;

    commit_ent_t          inc, head, wr;
    commit_ent_t          ents [DEPTH];
    logic [DEPTH_BIT-1:0] head_ptr, idx;
    logic [DEPTH_BIT:0]   count;
    logic                 full, empty, enq, deq, byp;

    assign inc = '{reg_id: bus.commit_reg_id,
                   val:    bus.commit_val,
                   rob_id: bus.commit_rob_id};

`ifdef COMMIT_BYPASS_EN
    assign byp = empty && bus.rdy_in && !bus.rob_clear
              && bus.commit_valid && (bus.commit_reg_id != 5'd0);
`else
    assign byp = 1'b0;
`endif

    // Ready depends on fullness only, never on this cycle's drain.
    assign bus.commit_ready = !full;
    assign bus.empty        = empty;

    assign enq = bus.commit_valid && !full && bus.rdy_in
              && (bus.commit_reg_id != 5'd0) && !byp;
    assign deq = !empty && bus.rdy_in && !bus.rob_clear;

    reg_commit_scheduler_commit_buffer #(.DEPTH_BIT(DEPTH_BIT)) u_buf (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .enq_i      (enq),
        .deq_i      (deq),
        .wdata_i    (inc),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .ents_o     (ents),
        .head_ptr_o (head_ptr),
        .count_o    (count)
    );

    always_comb begin
        wr = '0;
        unique case (1'b1)
            deq:     wr = head;
            byp:     wr = inc;
            default: wr = '0;
        endcase
    end

    assign bus.set_reg_id        = wr.reg_id;
    assign bus.set_val           = wr.val;
    assign bus.set_reg_on_rob_id = wr.rob_id;

    // Walk oldest to youngest so the last match is the newest value.
    always_comb begin
        bus.q_hit1 = 1'b0;
        bus.q_val1 = '0;
        bus.q_hit2 = 1'b0;
        bus.q_val2 = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + DEPTH_BIT'(i);
            if (CW'(i) < count) begin
                if (bus.q_id1 != 5'd0 && ents[idx].reg_id == bus.q_id1) begin
                    bus.q_hit1 = 1'b1;
                    bus.q_val1 = ents[idx].val;
                end
                if (bus.q_id2 != 5'd0 && ents[idx].reg_id == bus.q_id2) begin
                    bus.q_hit2 = 1'b1;
                    bus.q_val2 = ents[idx].val;
                end
            end
        end
    end

endmodule
